// File: rtl/sntrup757_pkg.sv
// rtl/sntrup757_pkg.sv - shared constants, state type and ternary codes for the sntrup757 polynomial blocks
package sntrup757_pkg;

  localparam int P      = 757;
  localparam int Q      = 5167;
  localparam int W      = 286;
  localparam int COEF_W = 13;
  localparam int ADDR_W = 10;
  localparam int NBYTES = 190;

  localparam logic [1:0] ENC_NEG  = 2'b00;
  localparam logic [1:0] ENC_ZERO = 2'b01;
  localparam logic [1:0] ENC_POS  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/small_encode_757_if.sv
// rtl/small_encode_757_if.sv - coefficient RAM read port and packed byte stream of the Small_encode packer
interface small_encode_757_if;

  logic                              rd_en;
  logic [sntrup757_pkg::ADDR_W-1:0]  rd_addr;
  logic [sntrup757_pkg::COEF_W-1:0]  rd_data;
  logic [7:0]                        out_data;
  logic                              out_valid;
  logic                              out_ready;

  modport master (
    output rd_en, rd_addr, out_data, out_valid,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_data, out_valid,
    output rd_data, out_ready
  );

endinterface

// File: rtl/small_enc_map.sv
// rtl/small_enc_map.sv - maps one 13-bit two's complement coefficient to its 2-bit Small_encode code
module small_enc_map
  import sntrup757_pkg::*;
(
  input  logic [COEF_W-1:0] coef,
  output logic [1:0]        code,
  output logic              illegal
);

  // Anything outside {-1, 0, 1} is encoded as zero and flagged
  always_comb begin
    code    = ENC_ZERO;
    illegal = 1'b0;
    if (coef == COEF_W'(0)) begin
      code = ENC_ZERO;
    end else if (coef == COEF_W'(1)) begin
      code = ENC_POS;
    end else if (coef == {COEF_W{1'b1}}) begin
      code = ENC_NEG;
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/small_encode_757.sv
// rtl/small_encode_757.sv - packs the 757-coefficient ternary polynomial into 190 Small_encode bytes; SMALL_ENC_WEIGHT_CHECK_EN adds weight_err
module small_encode_757
  import sntrup757_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                spoly_done,
  small_encode_757_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                err
`ifdef SMALL_ENC_WEIGHT_CHECK_EN
  ,
  output logic                weight_err
`endif
);

  state_e              state;
  logic [7:0]          k;
  logic [ADDR_W-1:0]   base;
  logic [1:0]          j;
  logic                cap_valid;
  logic [1:0]          cap_lane;
  logic [7:0]          acc;
  logic [1:0]          code;
  logic                illegal;
  logic                last_byte;
  logic                accept;
  logic                handshake;

  small_enc_map u_map (
    .coef    (bus.rd_data),
    .code    (code),
    .illegal (illegal)
  );

  assign last_byte = (k == 8'(NBYTES - 1));
  assign accept    = (state == ST_IDLE) && start && spoly_done;
  assign handshake = (state == ST_EMIT) && bus.out_ready;

  always_comb begin
    bus.rd_en     = (state == ST_RD);
    bus.rd_addr   = (state == ST_RD) ? (base + {{(ADDR_W-2){1'b0}}, j}) : '0;
    bus.out_valid = (state == ST_EMIT);
    bus.out_data  = (state == ST_EMIT) ? acc : 8'h00;
    busy          = (state != ST_IDLE);
    done          = (state == ST_DONE);
  end

  // Read data lands one cycle after its strobe, so the lane travels with a delayed valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      k         <= 8'd0;
      base      <= '0;
      j         <= 2'd0;
      cap_valid <= 1'b0;
      cap_lane  <= 2'd0;
      acc       <= 8'h00;
      err       <= 1'b0;
    end else begin
      cap_valid <= (state == ST_RD);
      cap_lane  <= j;
      if (cap_valid) begin
        acc[{cap_lane, 1'b0} +: 2] <= code;
        if (illegal) err <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_RD;
            base  <= '0;
            k     <= 8'd0;
            j     <= 2'd0;
            acc   <= 8'h00;
            err   <= 1'b0;
          end
        end
        ST_RD: begin
          if (j == (last_byte ? 2'd0 : 2'd3)) begin
            state <= ST_WAIT;
            j     <= 2'd0;
          end else begin
            j <= j + 2'd1;
          end
        end
        ST_WAIT: state <= ST_EMIT;
        ST_EMIT: begin
          if (handshake) begin
            if (last_byte) begin
              state <= ST_DONE;
            end else begin
              state <= ST_RD;
              base  <= base + ADDR_W'(4);
              k     <= k + 8'd1;
              acc   <= 8'h00;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SMALL_ENC_WEIGHT_CHECK_EN
  logic [9:0] wcount;

  // Last coefficient is captured during WAIT, so the count is final by the last handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcount     <= 10'd0;
      weight_err <= 1'b0;
    end else if (accept) begin
      wcount     <= 10'd0;
      weight_err <= 1'b0;
    end else begin
      if (cap_valid && !illegal && (code != ENC_ZERO)) wcount <= wcount + 10'd1;
      if (handshake && last_byte) weight_err <= (wcount != 10'(W));
    end
  end
`endif

endmodule
